// File: rtl/light_dance_pkg.sv
// Shared types and default sizing for the light-dance serial chain.
package light_dance_pkg;

  localparam int unsigned LD_WIDTH       = 8;
  localparam int unsigned LD_HOLD_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } ld_tx_state_t;

endpackage

// File: rtl/light_hold_timer.sv
// Step-interval down-counter: i_start loads HOLD_CYCLES, o_expired flags the final hold cycle.
module light_hold_timer #(
  parameter int unsigned HOLD_CYCLES = light_dance_pkg::LD_HOLD_CYCLES
) (
  input  logic clk,
  input  logic arst,
  input  logic i_start,
  output logic o_expired
);

  localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CntW'(HOLD_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // High while the last of the HOLD_CYCLES cycles is being spent.
  assign o_expired = (r_cnt == CntW'(1));

endmodule

// File: rtl/light_serial_tx.sv
// Serial pattern writer for the light-dance flip-flop chain: MSB-first shift, latch strobe,
// then a programmable hold before the next pattern is accepted.
module light_serial_tx
  import light_dance_pkg::*;
#(
  parameter int unsigned WIDTH       = LD_WIDTH,
  parameter int unsigned HOLD_CYCLES = LD_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             sdout,
  output logic             sload,
  output logic             slatch,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);

  ld_tx_state_t     r_state;
  ld_tx_state_t     w_state_d;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_d;
  logic [BitW-1:0]  r_bit_cnt;
  logic [BitW-1:0]  w_bit_cnt_d;
  logic             r_sdout;
  logic             r_sload;
  logic             r_slatch;
  logic             r_done;
  logic             w_sdout_d;
  logic             w_sload_d;
  logic             w_slatch_d;
  logic             w_done_d;
  logic             w_accept;
  logic             w_hold_start;
  logic             w_hold_expired;

  assign pat_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = pat_valid & pat_ready;

  assign sdout  = r_sdout;
  assign sload  = r_sload;
  assign slatch = r_slatch;
  assign done   = r_done;

  light_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk       (clk),
    .arst      (arst),
    .i_start   (w_hold_start),
    .o_expired (w_hold_expired)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_d = SHIFT;
      SHIFT:   if (r_bit_cnt == BitW'(1)) w_state_d = LATCH;
      LATCH:   w_state_d = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD:    if (w_hold_expired) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on the same
  // edge as the state and carry no combinational path from the inputs.
  always_comb begin
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    if (w_accept) begin
      w_shreg_d   = pat_in;
      w_bit_cnt_d = BitW'(WIDTH);
    end else if (r_state == SHIFT) begin
      w_shreg_d   = r_shreg << 1;
      w_bit_cnt_d = r_bit_cnt - BitW'(1);
    end
    w_sload_d    = (w_state_d == SHIFT);
    w_sdout_d    = (w_state_d == SHIFT) ? w_shreg_d[WIDTH-1] : 1'b0;
    w_slatch_d   = (w_state_d == LATCH);
    w_done_d     = (w_state_d == IDLE) && ((r_state == LATCH) || (r_state == HOLD));
    w_hold_start = (r_state == LATCH) && (w_state_d == HOLD);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_sdout   <= 1'b0;
      r_sload   <= 1'b0;
      r_slatch  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_sdout   <= w_sdout_d;
      r_sload   <= w_sload_d;
      r_slatch  <= w_slatch_d;
      r_done    <= w_done_d;
    end
  end

endmodule

// File: tb/tb_light_serial_tx.sv
// Directed bench for light_serial_tx: three instances cover WIDTH/HOLD combinations.
module tb_light_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       arst8, valid8, ready8, sdout8, sload8, slatch8, busy8, done8;
  logic [7:0] pat8;
  logic       arst0, valid0, ready0, sdout0, sload0, slatch0, busy0, done0;
  logic [7:0] pat0;
  logic       arst2, valid2, ready2, sdout2, sload2, slatch2, busy2, done2;
  logic [1:0] pat2;

  // Model of an 8-stage load-enabled DFF chain fed by the WIDTH=8 instance.
  logic [7:0] chain8;
  always @(negedge clk) if (sload8) chain8 <= {chain8[6:0], sdout8};

  light_serial_tx #(.WIDTH(8), .HOLD_CYCLES(4)) u_dut8 (
    .clk(clk), .arst(arst8), .pat_in(pat8), .pat_valid(valid8), .pat_ready(ready8),
    .sdout(sdout8), .sload(sload8), .slatch(slatch8), .busy(busy8), .done(done8)
  );

  light_serial_tx #(.WIDTH(8), .HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .arst(arst0), .pat_in(pat0), .pat_valid(valid0), .pat_ready(ready0),
    .sdout(sdout0), .sload(sload0), .slatch(slatch0), .busy(busy0), .done(done0)
  );

  light_serial_tx #(.WIDTH(2), .HOLD_CYCLES(1)) u_dut2 (
    .clk(clk), .arst(arst2), .pat_in(pat2), .pat_valid(valid2), .pat_ready(ready2),
    .sdout(sdout2), .sload(sload2), .slatch(slatch2), .busy(busy2), .done(done2)
  );

  // Frame on the WIDTH=8/HOLD=4 instance, starting at a negedge with the DUT idle.
  // mode 0: drop valid after accept; 1: toggle valid with 3C while busy, leave it high;
  // 2: keep valid high and present next_pat for the following frame.
  task automatic frame8(input logic [7:0] pat, input int mode, input logic [7:0] next_pat);
    logic [6:0] obs;
    logic [6:0] exp;
    checks++;
    if (ready8 !== 1'b1) begin
      failures++; $display("FAIL ready_at_start pat=%0h: got %b expected 1", pat, ready8);
    end
    pat8   = pat;
    valid8 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      obs = {sdout8, sload8, slatch8, busy8, ready8, done8, 1'b0};
      if (i <= 8)       exp = {pat[8-i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      else if (i == 9)  exp = 7'b0011000;
      else if (i < 14)  exp = 7'b0001000;
      else              exp = 7'b0000110;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL frame pat=%0h cycle %0d {sdout,sload,slatch,busy,ready,done}: got %b expected %b",
                 pat, i, obs[6:1], exp[6:1]);
      end
      if (i == 9) begin
        checks++;
        if (chain8 !== pat) begin
          failures++; $display("FAIL chain_at_latch: got %0h expected %0h", chain8, pat);
        end
      end
      if (mode == 0) begin
        valid8 = 1'b0;
      end else if (mode == 1) begin
        if (i < 14) begin
          valid8 = ((i % 2) == 1);
          pat8   = 8'h3C;
        end
      end else if (i == 1) begin
        pat8 = next_pat;
      end
    end
  endtask

  task automatic test_reset();
    arst8 = 1'b1; arst0 = 1'b1; arst2 = 1'b1;
    valid8 = 1'b0; valid0 = 1'b0; valid2 = 1'b0;
    pat8 = '0; pat0 = '0; pat2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sdout8, sload8, slatch8, busy8, ready8, done8} !== 6'b000010) begin
      failures++;
      $display("FAIL reset_dut8: got %b expected 000010", {sdout8, sload8, slatch8, busy8, ready8, done8});
    end
    checks++;
    if ({sdout0, sload0, slatch0, busy0, ready0, done0, sdout2, sload2, slatch2, busy2, ready2, done2}
        !== 12'b000010_000010) begin
      failures++;
      $display("FAIL reset_dut0_dut2: got %b expected 000010000010",
               {sdout0, sload0, slatch0, busy0, ready0, done0, sdout2, sload2, slatch2, busy2, ready2, done2});
    end
    arst8 = 1'b0; arst0 = 1'b0; arst2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy8, done8, busy0, done0, busy2, done2} !== 6'b0) begin
        failures++;
        $display("FAIL no_done_after_reset: got %b expected 000000", {busy8, done8, busy0, done0, busy2, done2});
      end
    end
  endtask

  task automatic test_single();
    frame8(8'hA5, 0, 8'h00);
    @(negedge clk);
    checks++;
    if ({done8, busy8, ready8} !== 3'b001) begin
      failures++; $display("FAIL done_one_pulse: got %b expected 001", {done8, busy8, ready8});
    end
  endtask

  task automatic test_back_to_back();
    frame8(8'hFF, 2, 8'h00);
    frame8(8'h00, 0, 8'h00);
    @(negedge clk);
    checks++;
    if ({busy8, ready8} !== 2'b01) begin
      failures++; $display("FAIL no_extra_accept: got %b expected 01", {busy8, ready8});
    end
  endtask

  task automatic test_ignore_busy();
    frame8(8'hE7, 1, 8'h00);
    frame8(8'h3C, 0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    pat8   = 8'hC3;
    valid8 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      valid8 = 1'b0;
    end
    arst8 = 1'b1;
    #1;
    checks++;
    if ({sdout8, sload8, slatch8, busy8, ready8, done8} !== 6'b000010) begin
      failures++;
      $display("FAIL async_reset_mid_frame: got %b expected 000010",
               {sdout8, sload8, slatch8, busy8, ready8, done8});
    end
    @(negedge clk);
    arst8 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if ({slatch8, done8, busy8} !== 3'b000) begin
        failures++;
        $display("FAIL after_reset_quiet cycle %0d: got %b expected 000", i, {slatch8, done8, busy8});
      end
    end
    frame8(8'h5A, 0, 8'h00);
  endtask

  task automatic test_hold0();
    logic [7:0] pat;
    logic [5:0] obs;
    logic [5:0] exp;
    pat    = 8'h81;
    pat0   = pat;
    valid0 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      valid0 = 1'b0;
      obs = {sdout0, sload0, slatch0, busy0, ready0, done0};
      if (i <= 8)      exp = {pat[8-i], 5'b10100};
      else if (i == 9) exp = 6'b001100;
      else             exp = 6'b000011;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL hold0 cycle %0d {sdout,sload,slatch,busy,ready,done}: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_width2();
    logic [5:0] obs;
    logic [5:0] exp;
    pat2   = 2'b10;
    valid2 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      valid2 = 1'b0;
      obs = {sdout2, sload2, slatch2, busy2, ready2, done2};
      case (i)
        1:       exp = 6'b110100;
        2:       exp = 6'b010100;
        3:       exp = 6'b001100;
        4:       exp = 6'b000100;
        5:       exp = 6'b000011;
        default: exp = 6'b000010;
      endcase
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL width2 cycle %0d {sdout,sload,slatch,busy,ready,done}: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_hold0();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
